// File: rtl/dac_multichan_dds.sv
`default_nettype none
// ============================================================================
// Module   : dac_multichan_dds
// Brief    : Multi-channel sine DDS driving NCH serial DACs over one shared
//            sclk/sync_n, with per-channel phase offsets into a fixed sine ROM.
// Revision : 1.0 - initial release
// ============================================================================

module dac_multichan_dds #(
    parameter int NCH  = 4,
    parameter int AW   = 6,
    parameter int DW   = 16,
    parameter int CTRL = 8,
    parameter int DIV  = 6,
    parameter int GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [AW-1:0]     step,
    input  logic [NCH*AW-1:0] offset,
    output logic              sclk,
    output logic              sync_n,
    output logic [NCH-1:0]    din,
    output logic              frame_done
);

    localparam int c_FL   = CTRL + DW;
    localparam int c_DCW  = $clog2(2 * DIV);
    localparam int c_BMAX = (c_FL > GAP) ? c_FL : GAP;
    localparam int c_BCW  = $clog2(c_BMAX + 1);

    localparam logic [c_DCW-1:0] c_DIV_HALF = c_DCW'(DIV - 1);
    localparam logic [c_DCW-1:0] c_DIV_LAST = c_DCW'(2 * DIV - 1);
    localparam logic [c_BCW-1:0] c_BIT_LAST = c_BCW'(c_FL - 1);
    localparam logic [c_BCW-1:0] c_GAP_LAST = c_BCW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Offset-binary sine sample, evaluated once at elaboration to build the ROM
    function automatic logic [DW-1:0] lut_entry(input int n);
        real amp;
        real ang;
        amp = real'((64'd1 << DW) - 64'd1) / 2.0;
        ang = 2.0 * 3.14159265358979323846 * real'(n) / real'(64'd1 << AW);
        return DW'($rtoi(amp + amp * $sin(ang) + 0.5));
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic               w_frame_end;
    logic               w_period_end;
    logic               w_bit_last;
    logic               w_gap_last;

    logic               r_sclk;
    logic               r_sync_n;
    logic               r_frame_done;
    logic [AW-1:0]      r_phase;
    logic [c_DCW-1:0]   r_div_cnt;
    logic [c_BCW-1:0]   r_bit_cnt;
    logic [c_FL-1:0]    r_shreg [NCH];

    logic [DW-1:0]      w_lut  [2**AW];
    logic [DW-1:0]      w_word [NCH];

    generate
        for (genvar n = 0; n < 2**AW; n++) begin : g_lut
            localparam logic [DW-1:0] c_ENTRY = lut_entry(n);
            assign w_lut[n] = c_ENTRY;
        end

        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [AW-1:0] w_addr;
            assign w_addr    = r_phase + offset[c*AW +: AW];
            assign w_word[c] = w_lut[w_addr];
            assign din[c]    = r_shreg[c][c_FL-1];
        end
    endgenerate

    assign sclk       = r_sclk;
    assign sync_n     = r_sync_n;
    assign frame_done = r_frame_done;

    // The divider counter times sclk periods in both SHIFT and GAP; the bit
    // counter doubles as the idle-period counter during GAP.
    assign w_period_end = (r_div_cnt == c_DIV_LAST);
    assign w_bit_last   = (r_bit_cnt == c_BIT_LAST);
    assign w_gap_last   = (r_bit_cnt == c_GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_period_end && w_bit_last) begin
                    w_frame_end = 1'b1;
                    if (GAP > 0) begin
                        w_state_next = ST_GAP;
                    end else begin
                        w_state_next = enable ? ST_LOAD : ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (w_period_end && w_gap_last) begin
                    w_state_next = enable ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk       <= 1'b0;
            r_sync_n     <= 1'b1;
            r_frame_done <= 1'b0;
            r_phase      <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_shreg[c] <= '0;
            end
        end else begin
            r_frame_done <= w_frame_end;
            case (r_state)
                ST_LOAD: begin
                    for (int c = 0; c < NCH; c++) begin
                        r_shreg[c] <= c_FL'(w_word[c]);
                    end
                    r_sclk    <= 1'b1;
                    r_sync_n  <= 1'b0;
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                end
                ST_SHIFT: begin
                    if (w_period_end) begin
                        r_div_cnt <= '0;
                        if (w_bit_last) begin
                            // Emptied shift registers keep din low between frames
                            for (int c = 0; c < NCH; c++) begin
                                r_shreg[c] <= '0;
                            end
                            r_sclk    <= 1'b0;
                            r_sync_n  <= 1'b1;
                            r_phase   <= r_phase + step;
                            r_bit_cnt <= '0;
                        end else begin
                            for (int c = 0; c < NCH; c++) begin
                                r_shreg[c] <= {r_shreg[c][c_FL-2:0], 1'b0};
                            end
                            r_sclk    <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                        if (r_div_cnt == c_DIV_HALF) begin
                            r_sclk <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_period_end) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= w_gap_last ? '0 : r_bit_cnt + 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                default: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dac_multichan_dds.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_multichan_dds
// Brief    : Frame-timeline reference model with per-cycle output compare,
//            serial word decoder and directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dac_multichan_dds;

    localparam int NCH  = 4;
    localparam int AW   = 6;
    localparam int DW   = 16;
    localparam int CTRL = 8;
    localparam int DIV  = 6;
    localparam int GAP  = 2;
    localparam int FL   = CTRL + DW;
    localparam int HP   = 2 * DIV;
    localparam int SHIFT_CLKS = FL * HP;
    localparam int PERIOD     = 1 + (FL + GAP) * HP;
    localparam int OW   = NCH * AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [AW-1:0]     step;
    logic [OW-1:0]     offset;
    logic              sclk;
    logic              sync_n;
    logic [NCH-1:0]    din;
    logic              frame_done;

    int n_vec = 0;
    int n_err = 0;

    dac_multichan_dds #(
        .NCH (NCH),
        .AW  (AW),
        .DW  (DW),
        .CTRL(CTRL),
        .DIV (DIV),
        .GAP (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .step      (step),
        .offset    (offset),
        .sclk      (sclk),
        .sync_n    (sync_n),
        .din       (din),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_lut(input int n);
        real amp;
        real v;
        amp = real'((longint'(1) << DW) - 1) / 2.0;
        v   = amp * (1.0 + $sin(2.0 * 3.141592653589793 * real'(n) / real'(1 << AW)));
        return DW'($rtoi(v + 0.5));
    endfunction

    // Reference model: position within the frame timeline (t=0 is the load clk)
    bit            m_busy = 1'b0;
    int            m_t = 0;
    int            m_phase = 0;
    logic [DW-1:0] m_word [NCH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_t     = 0;
            m_phase = 0;
        end else if (!m_busy) begin
            if (enable) begin
                m_busy = 1'b1;
                m_t    = 0;
            end
        end else begin
            if (m_t == 0) begin
                for (int c = 0; c < NCH; c++) begin
                    m_word[c] = ref_lut((m_phase + int'(offset[c*AW +: AW])) % (1 << AW));
                end
            end
            if (m_t == SHIFT_CLKS) begin
                m_phase = (m_phase + int'(step)) % (1 << AW);
            end
            m_t++;
            if (m_t == PERIOD) begin
                if (enable) m_t = 0;
                else        m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : p_cmp
        logic           e_sclk;
        logic           e_sync;
        logic           e_fd;
        logic [NCH-1:0] e_din;
        logic [FL-1:0]  fw;
        int             k;
        int             b;
        e_sclk = 1'b0;
        e_sync = 1'b1;
        e_fd   = 1'b0;
        e_din  = '0;
        if (rst_n && m_busy) begin
            if (m_t >= 1 && m_t <= SHIFT_CLKS) begin
                k      = m_t - 1;
                b      = k / HP;
                e_sync = 1'b0;
                e_sclk = (k % HP) < DIV;
                for (int c = 0; c < NCH; c++) begin
                    fw       = FL'(m_word[c]);
                    e_din[c] = fw[FL-1-b];
                end
            end
            if (m_t == SHIFT_CLKS + 1) e_fd = 1'b1;
        end
        n_vec++;
        if ({sclk, sync_n, din, frame_done} !== {e_sclk, e_sync, e_din, e_fd}) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0d busy=%0d: got sclk=%b sync_n=%b din=%b frame_done=%b, want sclk=%b sync_n=%b din=%b frame_done=%b",
                     m_t, m_busy, sclk, sync_n, din, frame_done, e_sclk, e_sync, e_din, e_fd);
        end
    end

    // Serial decoder: captures what a DAC would latch on sclk falling edges
    int            cyc = 0;
    int            nbits = 0;
    int            frame_bits = 0;
    int            frames_seen = 0;
    int            low_start = 0;
    int            low_len = 0;
    int            fd_last = 0;
    int            fd_gap = 0;
    int            fd_count = 0;
    logic [FL-1:0] cap   [NCH];
    logic [FL-1:0] words [NCH];

    always @(posedge clk) cyc++;

    always @(negedge sync_n) begin
        low_start = cyc;
        nbits     = 0;
        for (int c = 0; c < NCH; c++) cap[c] = '0;
    end

    always @(negedge sclk) begin
        if (sync_n === 1'b0) begin
            for (int c = 0; c < NCH; c++) cap[c] = {cap[c][FL-2:0], din[c]};
            nbits++;
        end
    end

    always @(posedge sync_n) begin
        low_len    = cyc - low_start;
        frame_bits = nbits;
        for (int c = 0; c < NCH; c++) words[c] = cap[c];
        frames_seen++;
    end

    always @(posedge frame_done) begin
        fd_gap  = cyc - fd_last;
        fd_last = cyc;
        fd_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_frame(input int budget);
        int start;
        int n;
        start = frames_seen;
        n = 0;
        while (frames_seen == start && n < budget) begin
            tick();
            n++;
        end
        check("wait_frame_timeout", 32'(frames_seen != start), 32'd1);
    endtask

    task automatic wait_low(input int budget);
        int n;
        n = 0;
        while (sync_n !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_sync_low_timeout", 32'(sync_n), 32'd0);
    endtask

    task automatic check_words(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        check({tag, "_ch0"}, 32'(words[0][DW-1:0]), 32'(w0));
        check({tag, "_ch1"}, 32'(words[1][DW-1:0]), 32'(w1));
        check({tag, "_ch2"}, 32'(words[2][DW-1:0]), 32'(w2));
        check({tag, "_ch3"}, 32'(words[3][DW-1:0]), 32'(w3));
    endtask

    initial begin
        int fd_before;
        int fr_before;
        rst_n  = 1'b0;
        enable = 1'b0;
        step   = '0;
        offset = '0;

        repeat (20) begin
            tick();
            enable = 1'($urandom);
        end
        check("reset_outputs", 32'({sclk, sync_n, din, frame_done}), 32'({1'b0, 1'b1, 4'b0000, 1'b0}));

        enable = 1'b0;
        offset = {6'd48, 6'd32, 6'd16, 6'd0};
        step   = 6'd7;
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;

        wait_frame(400);
        check_words("frame0", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000);
        check("frame0_ctrl_ch0", 32'(words[0][FL-1:DW]), 32'd0);
        check("frame0_ctrl_ch3", 32'(words[3][FL-1:DW]), 32'd0);
        check("frame0_bits", 32'(frame_bits), 32'd24);
        check("sync_low_clks", 32'(low_len), 32'd288);

        wait_frame(400);
        check("frame1_ch0", 32'(words[0][DW-1:0]), 32'h0000_D133);
        check("frame_done_spacing", 32'(fd_gap), 32'd313);

        repeat (9) wait_frame(400);
        check("wrap_phase6_ch0", 32'(words[0][DW-1:0]), 32'h0000_C71C);

        // Drop enable partway into bit 5 of the next frame
        wait_low(400);
        repeat (5 * HP + 2) tick();
        enable    = 1'b0;
        fd_before = fd_count;
        fr_before = frames_seen;
        wait_frame(400);
        check("drop_frame_bits", 32'(frame_bits), 32'd24);
        repeat (3) tick();
        check("drop_frame_done", 32'(fd_count), 32'(fd_before + 1));
        repeat (400) tick();
        check("drop_no_reload", 32'(frames_seen), 32'(fr_before + 1));
        check("drop_idle_sync", 32'(sync_n), 32'd1);

        enable = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            tick();
            if ($urandom_range(0, 63) == 0)  offset = OW'($urandom);
            if ($urandom_range(0, 63) == 0)  step = AW'($urandom);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            rst_n = ($urandom_range(0, 2499) != 0);
        end

        // Reset during bit 12 of a frame
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        wait_low(800);
        repeat (12 * HP + 3) tick();
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame", 32'({sclk, sync_n, din, frame_done}), 32'({1'b0, 1'b1, 4'b0000, 1'b0}));
        offset = {6'd32, 6'd0, 6'd48, 6'd16};
        step   = 6'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        wait_frame(800);
        check_words("post_reset", 16'hFFFF, 16'h0000, 16'h8000, 16'h8000);
        check("post_reset_bits", 32'(frame_bits), 32'd24);

        // step=0: offset change lands at the next load, then words repeat
        offset = {6'd32, 6'd0, 6'd48, 6'd7};
        wait_frame(400);
        check("step0_a_ch0", 32'(words[0][DW-1:0]), 32'h0000_D133);
        wait_frame(400);
        check("step0_b_ch0", 32'(words[0][DW-1:0]), 32'h0000_D133);
        check("step0_b_ch1", 32'(words[1][DW-1:0]), 32'h0000_0000);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
